// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: opcodes, FSM states,
// datapath mux selectors and the decoded control bundle.
package mips_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [5:0] FUNCT_JR = 6'b001000;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_R_EXEC   = 4'd2,
      S_R_WB     = 4'd3,
      S_I_EXEC   = 4'd4,
      S_I_WB     = 4'd5,
      S_MEM_ADDR = 4'd6,
      S_MEM_RD   = 4'd7,
      S_MEM_WB   = 4'd8,
      S_MEM_WR   = 4'd9,
      S_BRANCH   = 4'd10,
      S_JUMP     = 4'd11,
      S_JR       = 4'd12,
      S_JAL      = 4'd13,
      S_TRAP     = 4'd14
   } state_t;

   typedef enum logic [1:0] {
      ALU_ADD    = 2'b00,
      ALU_SUB    = 2'b01,
      ALU_FUNCT  = 2'b10,
      ALU_OPCODE = 2'b11
   } alu_op_t;

   typedef enum logic [1:0] {
      PC_ALU    = 2'b00,
      PC_ALUOUT = 2'b01,
      PC_JUMP   = 2'b10,
      PC_RS     = 2'b11
   } pc_src_t;

   typedef enum logic [1:0] {
      RD_RT = 2'b00,
      RD_RD = 2'b01,
      RD_RA = 2'b10
   } reg_dst_t;

   typedef enum logic [1:0] {
      WD_ALUOUT = 2'b00,
      WD_MDR    = 2'b01,
      WD_PC     = 2'b10
   } mem_to_reg_t;

   typedef enum logic [1:0] {
      SRCB_RT      = 2'b00,
      SRCB_FOUR    = 2'b01,
      SRCB_IMM     = 2'b10,
      SRCB_IMM_SH2 = 2'b11
   } alu_src_b_t;

   // One-hot instruction class; an all-zero value flags an illegal opcode.
   typedef struct packed {
      logic r_type;
      logic jr;
      logic lw;
      logic sw;
      logic addi;
      logic logic_imm;
      logic beq;
      logic jump;
      logic jal;
   } op_class_t;

   typedef struct packed {
      logic        pc_write;
      logic        pc_write_cond;
      logic        iord;
      logic        mem_read;
      logic        mem_write;
      logic        ir_write;
      reg_dst_t    reg_dst;
      mem_to_reg_t mem_to_reg;
      logic        reg_write;
      logic        alu_src_a;
      alu_src_b_t  alu_src_b;
      alu_op_t     alu_op;
      pc_src_t     pc_source;
   } ctrl_t;

   function automatic logic is_mem_wait_state(input state_t s);
      return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
   endfunction

endpackage

// File: rtl/mips_op_classifier.sv
// Combinational opcode/funct decoder producing a one-hot instruction class
// and an illegal flag for opcodes the control unit does not implement.
module mips_op_classifier
   import mips_ctrl_pkg::*;
#(
   parameter int OPCODE_W = 6
) (
   input  logic [OPCODE_W-1:0] opcode,
   input  logic [OPCODE_W-1:0] funct,
   output op_class_t           op_class,
   output logic                illegal
);

   always_comb begin
      op_class = '0;
      case (opcode)
         OP_RTYPE: begin
            if (funct == FUNCT_JR) begin
               op_class.jr = 1'b1;
            end else begin
               op_class.r_type = 1'b1;
            end
         end
         OP_LW:   op_class.lw        = 1'b1;
         OP_SW:   op_class.sw        = 1'b1;
         OP_ADDI: op_class.addi      = 1'b1;
         OP_ANDI: op_class.logic_imm = 1'b1;
         OP_ORI:  op_class.logic_imm = 1'b1;
         OP_BEQ:  op_class.beq       = 1'b1;
         OP_J:    op_class.jump      = 1'b1;
         OP_JAL:  op_class.jal       = 1'b1;
         default: op_class = '0;
      endcase
   end

   assign illegal = (op_class == '0);

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM: sequences each instruction, bounds memory waits
// with a timeout, traps on illegal opcodes and drives all datapath controls.
module mips_multicycle_control
   import mips_ctrl_pkg::*;
#(
   parameter int OPCODE_W    = 6,
   parameter int ALUOP_W     = 2,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic [OPCODE_W-1:0] funct,
   input  logic                zero,
   input  logic                mem_ready,
   output logic                pc_write,
   output logic                pc_write_cond,
   output logic                iord,
   output logic                mem_read,
   output logic                mem_write,
   output logic                ir_write,
   output logic [1:0]          reg_dst,
   output logic [1:0]          mem_to_reg,
   output logic                reg_write,
   output logic                alu_src_a,
   output logic [1:0]          alu_src_b,
   output logic [ALUOP_W-1:0]  alu_op,
   output logic [1:0]          pc_source,
   output logic                illegal_op,
   output logic                mem_error,
   output logic [3:0]          state_o
);

   localparam int                CNT_W    = $clog2(MEM_TIMEOUT + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
   logic              illegal_q, illegal_d;
   logic              mem_err_q, mem_err_d;
   logic              is_store_q, is_store_d;
   logic              is_logic_q, is_logic_d;

   op_class_t         op_class;
   logic              op_illegal;
   logic              wait_expired;
   ctrl_t             ctrl;
   logic              run;

   // The branch decision on zero is taken in the datapath via pc_write_cond.
   logic              unused_zero;
   assign unused_zero = zero;

   mips_op_classifier #(
      .OPCODE_W (OPCODE_W)
   ) u_classifier (
      .opcode   (opcode),
      .funct    (funct),
      .op_class (op_class),
      .illegal  (op_illegal)
   );

   assign wait_expired = (wait_cnt_q == CNT_LAST) && !mem_ready;

   always_comb begin
      state_d    = state_q;
      illegal_d  = illegal_q;
      mem_err_d  = mem_err_q;
      is_store_d = is_store_q;
      is_logic_d = is_logic_q;
      case (state_q)
         S_FETCH: begin
            if (mem_ready) begin
               state_d = S_DECODE;
            end else if (wait_expired) begin
               state_d   = S_TRAP;
               mem_err_d = 1'b1;
            end
         end
         S_DECODE: begin
            is_store_d = op_class.sw;
            is_logic_d = op_class.logic_imm;
            if (op_illegal) begin
               state_d   = S_TRAP;
               illegal_d = 1'b1;
            end else if (op_class.r_type) begin
               state_d = S_R_EXEC;
            end else if (op_class.jr) begin
               state_d = S_JR;
            end else if (op_class.lw || op_class.sw) begin
               state_d = S_MEM_ADDR;
            end else if (op_class.addi || op_class.logic_imm) begin
               state_d = S_I_EXEC;
            end else if (op_class.beq) begin
               state_d = S_BRANCH;
            end else if (op_class.jump) begin
               state_d = S_JUMP;
            end else begin
               state_d = S_JAL;
            end
         end
         S_R_EXEC:   state_d = S_R_WB;
         S_I_EXEC:   state_d = S_I_WB;
         S_MEM_ADDR: state_d = is_store_q ? S_MEM_WR : S_MEM_RD;
         S_MEM_RD: begin
            if (mem_ready) begin
               state_d = S_MEM_WB;
            end else if (wait_expired) begin
               state_d   = S_TRAP;
               mem_err_d = 1'b1;
            end
         end
         S_MEM_WR: begin
            if (mem_ready) begin
               state_d = S_FETCH;
            end else if (wait_expired) begin
               state_d   = S_TRAP;
               mem_err_d = 1'b1;
            end
         end
         S_R_WB, S_I_WB, S_MEM_WB,
         S_BRANCH, S_JUMP, S_JR, S_JAL: state_d = S_FETCH;
         S_TRAP:     state_d = S_TRAP;
         default:    state_d = S_FETCH;
      endcase
   end

   // Counter measures consecutive stalled cycles within one memory state only.
   always_comb begin
      wait_cnt_d = wait_cnt_q;
      if (state_d != state_q) begin
         wait_cnt_d = '0;
      end else if (is_mem_wait_state(state_q) && !mem_ready) begin
         wait_cnt_d = wait_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_FETCH;
         wait_cnt_q <= '0;
         illegal_q  <= 1'b0;
         mem_err_q  <= 1'b0;
         is_store_q <= 1'b0;
         is_logic_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         illegal_q  <= illegal_d;
         mem_err_q  <= mem_err_d;
         is_store_q <= is_store_d;
         is_logic_q <= is_logic_d;
      end
   end

   always_comb begin
      ctrl = '0;
      case (state_q)
         S_FETCH: begin
            ctrl.mem_read  = 1'b1;
            ctrl.pc_write  = mem_ready;
            ctrl.ir_write  = mem_ready;
            ctrl.alu_src_b = SRCB_FOUR;
         end
         S_DECODE: begin
            ctrl.alu_src_b = SRCB_IMM_SH2;
         end
         S_R_EXEC: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_RT;
            ctrl.alu_op    = ALU_FUNCT;
         end
         S_R_WB: begin
            ctrl.reg_dst   = RD_RD;
            ctrl.reg_write = 1'b1;
         end
         S_I_EXEC: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.alu_op    = is_logic_q ? ALU_OPCODE : ALU_ADD;
         end
         S_I_WB: begin
            ctrl.reg_write = 1'b1;
         end
         S_MEM_ADDR: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
         end
         S_MEM_RD: begin
            ctrl.mem_read = 1'b1;
            ctrl.iord     = 1'b1;
         end
         S_MEM_WB: begin
            ctrl.mem_to_reg = WD_MDR;
            ctrl.reg_write  = 1'b1;
         end
         S_MEM_WR: begin
            ctrl.mem_write = 1'b1;
            ctrl.iord      = 1'b1;
         end
         S_BRANCH: begin
            ctrl.alu_src_a     = 1'b1;
            ctrl.alu_src_b     = SRCB_RT;
            ctrl.alu_op        = ALU_SUB;
            ctrl.pc_write_cond = 1'b1;
            ctrl.pc_source     = PC_ALUOUT;
         end
         S_JUMP: begin
            ctrl.pc_write  = 1'b1;
            ctrl.pc_source = PC_JUMP;
         end
         S_JR: begin
            ctrl.pc_write  = 1'b1;
            ctrl.pc_source = PC_RS;
         end
         S_JAL: begin
            ctrl.pc_write   = 1'b1;
            ctrl.pc_source  = PC_JUMP;
            ctrl.reg_write  = 1'b1;
            ctrl.reg_dst    = RD_RA;
            ctrl.mem_to_reg = WD_PC;
         end
         default: ctrl = '0;
      endcase
   end

   // Reset masks every output combinationally, even before the next clock edge.
   assign run           = !rst;
   assign pc_write      = run & ctrl.pc_write;
   assign pc_write_cond = run & ctrl.pc_write_cond;
   assign iord          = run & ctrl.iord;
   assign mem_read      = run & ctrl.mem_read;
   assign mem_write     = run & ctrl.mem_write;
   assign ir_write      = run & ctrl.ir_write;
   assign reg_dst       = run ? ctrl.reg_dst : 2'b00;
   assign mem_to_reg    = run ? ctrl.mem_to_reg : 2'b00;
   assign reg_write     = run & ctrl.reg_write;
   assign alu_src_a     = run & ctrl.alu_src_a;
   assign alu_src_b     = run ? ctrl.alu_src_b : 2'b00;
   assign alu_op        = run ? ALUOP_W'(ctrl.alu_op) : '0;
   assign pc_source     = run ? ctrl.pc_source : 2'b00;
   assign illegal_op    = run & illegal_q;
   assign mem_error     = run & mem_err_q;
   assign state_o       = run ? 4'(state_q) : 4'd0;

endmodule
